// File: rtl/fifo_in_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_in_resp_pkg
// Brief  : Shared defaults and pointer/count types for the FIFO_in responder.
// Rev    : 1.0
// ============================================================================
package fifo_in_resp_pkg;

    localparam int C_DATA_WIDTH = 128;
    localparam int C_DEPTH      = 16;
    localparam int C_AF_MARGIN  = 2;

    localparam int PTR_W = $clog2(C_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

endpackage
`default_nettype wire

// File: rtl/fifo_in_mem.sv
`default_nettype none
// ============================================================================
// Module : fifo_in_mem
// Brief  : DEPTH x DATA_WIDTH storage, one sync write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module fifo_in_mem
    import fifo_in_resp_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH      = C_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_in_responder.sv
`default_nettype none
// ============================================================================
// Module : fifo_in_responder
// Brief  : Responder-side sync FIFO with occupancy and sticky over/underflow.
// Rev    : 1.0
// ============================================================================
module fifo_in_responder
    import fifo_in_resp_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH      = C_DEPTH,
    parameter int AF_MARGIN  = C_AF_MARGIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_LVL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_LVL   = c_CNT_W'(DEPTH - AF_MARGIN);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_mem_we;
    logic w_mem_re;

    // Flags decode from the count register only, so they never see this cycle's requests.
    assign w_full   = (r_count == c_FULL_LVL);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_mem_we = w_wr_acc & rst;
    assign w_mem_re = w_rd_acc & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= r_overflow  | (wr_en & w_full);
            r_underflow <= r_underflow | (rd_en & w_empty);
        end
    end

    fifo_in_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (c_PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_mem_we),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_mem_re),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_AF_LVL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire
